lfsr_checker: RTL and testbench

Receive-side companion to the cache's 5-bit Fibonacci LFSR. It consumes the word stream the LFSR produces, one word per advance, and self-synchronises to that stream. Once locked, it flags and counts every word that deviates from the predicted sequence. It is used on the replacement-policy path and in self-test to confirm that the pseudo-random victim selector is advancing correctly and has not stalled or been corrupted.

---
 rtl/lfsr_checker.sv | 152 +++++++++++++++
 tb/tb_lfsr_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 5-bit Fibonacci LFSR word stream: self-synchronises,
// then flags and counts every word that departs from the predicted sequence.
module lfsr_checker #(
    parameter int BITS        = 5,
    parameter int LOCK_COUNT  = 4,
    parameter int UNLOCK_ERRS = 3,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    // Handshake: in_valid qualifies in_data for exactly one cycle; there is no
    // ready, the block consumes every valid word on the edge it is presented.
    input  logic             in_valid,
    input  logic [BITS-1:0]  in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [BITS-1:0]  expected,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int MC_W = $clog2(LOCK_COUNT + 1);
    localparam int MS_W = $clog2(UNLOCK_ERRS + 1);
    localparam logic [MC_W-1:0] LOCK_V   = MC_W'(LOCK_COUNT);
    localparam logic [MS_W-1:0] UNLOCK_V = MS_W'(UNLOCK_ERRS);

    // One shift of the generator: feedback from taps 4 and 1 enters at the top.
    function automatic logic [BITS-1:0] lfsr_step(input logic [BITS-1:0] s);
        return {s[4] ^ s[1], s[4:1]};
    endfunction

    // One word advance is a full BITS-step refresh of the register.
    function automatic logic [BITS-1:0] lfsr_next(input logic [BITS-1:0] w);
        logic [BITS-1:0] t;
        t = w;
        for (int i = 0; i < BITS; i++) begin
            t = lfsr_step(t);
        end
        return t;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [MS_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic [BITS-1:0]  expected_q, expected_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             err_pulse_q, err_pulse_d;

    logic [BITS-1:0] word_next;
    logic [BITS-1:0] exp_next;
    logic            is_match;
    logic            word_zero;

    assign word_next = lfsr_next(in_data);
    assign exp_next  = lfsr_next(expected_q);
    assign is_match  = (in_data == expected_q);
    assign word_zero = (in_data == '0);

    always_comb begin
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        expected_d  = expected_q;
        err_pulse_d = 1'b0;

        if (in_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (!word_zero) begin
                        expected_d  = word_next;
                        match_cnt_d = '0;
                        state_d     = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (is_match) begin
                        expected_d  = word_next;
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_d == LOCK_V) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else if (!word_zero) begin
                        expected_d  = word_next;
                        match_cnt_d = '0;
                    end else begin
                        match_cnt_d = '0;
                        state_d     = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    if (is_match) begin
                        expected_d = word_next;
                        miss_cnt_d = '0;
                    end else begin
                        // Flywheel on the prediction so corrupt data never reseeds us.
                        err_pulse_d = 1'b1;
                        expected_d  = exp_next;
                        miss_cnt_d  = miss_cnt_q + 1'b1;
                        if (miss_cnt_d == UNLOCK_V) begin
                            state_d    = ST_SEARCH;
                            miss_cnt_d = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    // A clear that coincides with a locked mismatch still records that mismatch.
    always_comb begin
        err_count_d = err_count_q;
        if (clear_cnt) begin
            err_count_d = err_pulse_d ? ERR_W'(1) : '0;
        end else if (err_pulse_d && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            expected_q  <= '1;
            err_count_q <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            expected_q  <= expected_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign expected  = expected_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, single and burst errors, zero words,
// input gaps, counter saturation (narrow counter instance) and mid-run reset.
module tb_lfsr_checker;

    localparam int BITS  = 5;
    localparam int ERR_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [BITS-1:0]  in_data;
    logic             clear_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
    logic [BITS-1:0]  expected;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [BITS-1:0] exp_q[$];
    logic [BITS-1:0] exp_m;
    logic [BITS-1:0] w;
    int              errs_sent;

    lfsr_checker #(
        .BITS(BITS),
        .LOCK_COUNT(4),
        .UNLOCK_ERRS(3),
        .ERR_W(ERR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .clear_cnt(clear_cnt),
        .locked(locked),
        .err_pulse(err_pulse),
        .err_count(err_count),
        .expected(expected),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference word advance: five single shifts of {s4^s1, s[4:1]}.
    function automatic logic [BITS-1:0] ref_next(input logic [BITS-1:0] x);
        logic [BITS-1:0] t;
        t = x;
        for (int i = 0; i < 5; i++) begin
            t = {t[4] ^ t[1], t[4:1]};
        end
        return t;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // driver: present inputs for one edge, return 1ns after that edge
    task automatic drive(input logic v, input logic [BITS-1:0] d, input logic c);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        clear_cnt = c;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clear_cnt = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_pulse", 32'(err_pulse), 32'd0);
        check_eq("rst_count", 32'(err_count), 32'd0);
        check_eq("rst_expected", 32'(expected), 32'h1f);
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [BITS-1:0] seq_a[5];
        logic [BITS-1:0] seq_b[5];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clear_cnt = 1'b0;
        seq_a = '{5'h1f, 5'h1a, 5'h04, 5'h1e, 5'h1a};
        seq_b = '{5'h15, 5'h09, 5'h1c, 5'h15, 5'h09};

        apply_reset(2);

        // Lock from reset on the 1f/1a/04/1e sequence
        exp_q = '{5'h1a, 5'h04, 5'h1e, 5'h1a, 5'h04};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq_a[i], 1'b0);
            check_eq($sformatf("lock_exp%0d", i), 32'(expected), 32'(exp_q.pop_front()));
            check_eq($sformatf("lock_lk%0d", i), 32'(locked), (i == 4) ? 32'd1 : 32'd0);
        end
        check_eq("lock_count", 32'(err_count), 32'd0);
        check_eq("lock_state", 32'(dbg_state), 32'd2);

        // Single corrupt word while locked, then the correct sequence resumes
        drive(1'b1, 5'h05, 1'b0);
        check_eq("one_pulse", 32'(err_pulse), 32'd1);
        check_eq("one_count", 32'(err_count), 32'd1);
        check_eq("one_locked", 32'(locked), 32'd1);
        check_eq("one_flywheel", 32'(expected), 32'h1e);
        drive(1'b1, 5'h1e, 1'b0);
        check_eq("one_resume_pulse", 32'(err_pulse), 32'd0);
        check_eq("one_resume_count", 32'(err_count), 32'd1);
        check_eq("one_resume_exp", 32'(expected), 32'h1a);

        // clear_cnt on a matching word, then three corrupt words drop lock
        drive(1'b1, 5'h1a, 1'b1);
        check_eq("clr_count", 32'(err_count), 32'd0);
        check_eq("clr_locked", 32'(locked), 32'd1);
        drive(1'b1, 5'h00, 1'b0);
        check_eq("burst1_pulse", 32'(err_pulse), 32'd1);
        check_eq("burst1_exp", 32'(expected), 32'h1e);
        drive(1'b1, 5'h03, 1'b0);
        check_eq("burst2_pulse", 32'(err_pulse), 32'd1);
        check_eq("burst2_locked", 32'(locked), 32'd1);
        drive(1'b1, 5'h03, 1'b0);
        check_eq("burst3_pulse", 32'(err_pulse), 32'd1);
        check_eq("burst3_count", 32'(err_count), 32'd3);
        check_eq("burst3_locked", 32'(locked), 32'd0);
        check_eq("burst3_exp", 32'(expected), 32'h04);

        // Relock from a different seed
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq_b[i], 1'b0);
            check_eq($sformatf("relock_lk%0d", i), 32'(locked), (i == 4) ? 32'd1 : 32'd0);
        end
        check_eq("relock_exp", 32'(expected), 32'h1c);
        check_eq("relock_count", 32'(err_count), 32'd3);

        // Unlock with zero words, then zeros in SEARCH are ignored
        for (int i = 0; i < 3; i++) drive(1'b1, 5'h00, 1'b0);
        check_eq("zero_unlock", 32'(locked), 32'd0);
        check_eq("zero_unlock_count", 32'(err_count), 32'd6);
        check_eq("zero_unlock_exp", 32'(expected), 32'h1c);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'h00, 1'b0);
            check_eq($sformatf("zero_state%0d", i), 32'(dbg_state), 32'd0);
            check_eq($sformatf("zero_pulse%0d", i), 32'(err_pulse), 32'd0);
        end
        check_eq("zero_exp", 32'(expected), 32'h1c);

        // Valid sequence with idle gaps between words
        exp_q = '{5'h1a, 5'h04, 5'h1e, 5'h1a, 5'h04};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, seq_a[i], 1'b0);
            w = exp_q.pop_front();
            check_eq($sformatf("gap_exp%0d", i), 32'(expected), 32'(w));
            drive(1'b0, 5'h0b, 1'b0);
            check_eq($sformatf("gap_hold%0d", i), 32'(expected), 32'(w));
            check_eq($sformatf("gap_state%0d", i), 32'(dbg_state), (i == 4) ? 32'd2 : 32'd1);
        end
        check_eq("gap_locked", 32'(locked), 32'd1);

        // One more error brings the count to 7, then reset mid-run
        drive(1'b1, 5'h07, 1'b0);
        check_eq("pre_rst_count", 32'(err_count), 32'd7);
        check_eq("pre_rst_locked", 32'(locked), 32'd1);
        apply_reset(1);

        // Saturation: lock, then alternate miss, miss, match to stay locked
        for (int i = 0; i < 5; i++) drive(1'b1, seq_a[i], 1'b0);
        exp_m     = 5'h04;
        errs_sent = 0;
        for (int it = 0; it < 130; it++) begin
            for (int k = 0; k < 2; k++) begin
                drive(1'b1, exp_m ^ 5'h10, 1'b0);
                exp_m = ref_next(exp_m);
                errs_sent++;
            end
            drive(1'b1, exp_m, 1'b0);
            exp_m = ref_next(exp_m);
            if (it == 126) check_eq("sat_254", 32'(err_count), 32'd254);
        end
        check_eq("sat_sent", 32'(errs_sent), 32'd260);
        check_eq("sat_count", 32'(err_count), 32'hff);
        check_eq("sat_locked", 32'(locked), 32'd1);
        check_eq("sat_exp", 32'(expected), 32'(exp_m));

        // clear_cnt coincident with a locked mismatch leaves a count of one
        drive(1'b1, exp_m ^ 5'h10, 1'b1);
        check_eq("clr_err_count", 32'(err_count), 32'd1);
        check_eq("clr_err_pulse", 32'(err_pulse), 32'd1);
        drive(1'b0, 5'h00, 1'b0);
        check_eq("idle_pulse", 32'(err_pulse), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
